// File: rtl/tb_stream_pkg.sv
// Shared types and helpers for the N-channel stream merger.
package tb_stream_pkg;

  // Channel count the shared channel-index type is sized for.
  localparam int DEFAULT_NUM_CH = 4;

  typedef logic [$clog2(DEFAULT_NUM_CH)-1:0] ch_idx_t;

  // Arbiter/grant state machine.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } merge_state_e;

  // Round-robin scan position: the channel 'offset' places after 'base', wrapping at num_ch.
  function automatic int rr_index(input int base, input int offset, input int num_ch);
    return (base + offset) % num_ch;
  endfunction

endpackage

// File: rtl/tb_stream_fifo.sv
// Synchronous FIFO with a registered occupancy count. The head word is readable
// combinationally, so a pop and its data belong to the same cycle.
module tb_stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_push;
  logic do_pop;

  // Flags come from the registered count only; a same-cycle pop never re-opens space.
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/tb_stream_merge.sv
// N-channel packet-aware stream merger: per-channel FIFOs, round-robin arbiter with
// optional packet locking, and a single registered output stage with channel sideband.
module tb_stream_merge
  import tb_stream_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_MODE   = 1
) (
  input  logic                       clk,
  input  logic                       MIB_MASTER_RESET,
  input  logic [NUM_CH*DATA_W-1:0]   t_data,
  input  logic [NUM_CH-1:0]          t_valid,
  input  logic [NUM_CH-1:0]          t_last,
  output logic [NUM_CH-1:0]          t_ready,
  input  logic [NUM_CH-1:0]          ch_enable,
  output logic [DATA_W-1:0]          i0_data,
  output logic                       i0_valid,
  output logic                       i0_last,
  output logic [$clog2(NUM_CH)-1:0]  i0_ch,
  input  logic                       i0_ready,
  output logic                       busy
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_pop;
  logic [DATA_W:0]   fifo_head [NUM_CH];

  merge_state_e      state_reg,    state_next;
  logic [CH_W-1:0]   grant_reg,    grant_next;
  logic [CH_W-1:0]   rr_reg,       rr_next;
  logic [DATA_W-1:0] i0_data_reg,  i0_data_next;
  logic              i0_valid_reg, i0_valid_next;
  logic              i0_last_reg,  i0_last_next;
  logic [CH_W-1:0]   i0_ch_reg,    i0_ch_next;

  logic              pick_found;
  logic [CH_W-1:0]   pick_idx;
  logic              load_ok;
  logic              pop_any;
  logic [DATA_W:0]   head_word;
  logic              head_last;

  // One FIFO per channel; each stores {last, data}.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Ready is forced low while reset is held so nothing is taken during the reset cycle.
      assign t_ready[gi]  = ~fifo_full[gi] & ~MIB_MASTER_RESET;
      assign fifo_pop[gi] = pop_any & (grant_reg == CH_W'(gi));

      tb_stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .srst      (MIB_MASTER_RESET),
        .push      (t_valid[gi] & t_ready[gi]),
        .push_data ({t_last[gi], t_data[gi*DATA_W +: DATA_W]}),
        .pop       (fifo_pop[gi]),
        .pop_data  (fifo_head[gi]),
        .empty     (fifo_empty[gi]),
        .full      (fifo_full[gi])
      );
    end
  endgenerate

  // The output register may take a new word when empty or being drained this cycle.
  assign load_ok   = ~i0_valid_reg | i0_ready;
  assign head_word = fifo_head[grant_reg];
  assign head_last = head_word[DATA_W];
  assign pop_any   = (state_reg == GRANT) & load_ok & ~fifo_empty[grant_reg];

  // Round-robin pick: first enabled, non-empty channel after the last winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!pick_found && !fifo_empty[rr_index(int'(rr_reg), k, NUM_CH)]
          && ch_enable[rr_index(int'(rr_reg), k, NUM_CH)]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(rr_index(int'(rr_reg), k, NUM_CH));
      end
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the grant until the packet (or single word) is popped.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          rr_next    = pick_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (pop_any && ((PKT_MODE == 0) || head_last)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output stage: load the popped word, or go invalid once the held word is taken.
  always_comb begin
    i0_data_next  = i0_data_reg;
    i0_valid_next = i0_valid_reg;
    i0_last_next  = i0_last_reg;
    i0_ch_next    = i0_ch_reg;
    if (load_ok) begin
      if (pop_any) begin
        i0_data_next  = head_word[DATA_W-1:0];
        i0_last_next  = head_last;
        i0_ch_next    = grant_reg;
        i0_valid_next = 1'b1;
      end else begin
        i0_valid_next = 1'b0;
      end
    end
  end

  // State and output registers; the rr pointer starts at the top so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (MIB_MASTER_RESET) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_reg       <= CH_W'(NUM_CH - 1);
      i0_data_reg  <= '0;
      i0_valid_reg <= 1'b0;
      i0_last_reg  <= 1'b0;
      i0_ch_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_reg       <= rr_next;
      i0_data_reg  <= i0_data_next;
      i0_valid_reg <= i0_valid_next;
      i0_last_reg  <= i0_last_next;
      i0_ch_reg    <= i0_ch_next;
    end
  end

  assign i0_data  = i0_data_reg;
  assign i0_valid = i0_valid_reg;
  assign i0_last  = i0_last_reg;
  assign i0_ch    = i0_ch_reg;
  assign busy     = (|(~fifo_empty)) | i0_valid_reg;

endmodule
